// File: rtl/avalon_wait_ram.sv
// Avalon-MM slave word memory with fixed or LFSR-driven wait states, byte-enable writes and a
// clocked loader port. Contents survive reset; err flags bus protocol violations until reset.
module avalon_wait_ram #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned RANDOM_WAIT = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  output logic        waitrequest,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        err
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW  = $clog2(WAIT_CYCLES + 2);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d, target_q, target_d, start_target;
  logic [15:0]           lfsr_q, lfsr_d;
  logic                  err_q, err_d;
  logic [31:0]           mem [Depth];
  logic [ADDR_WIDTH-1:0] bus_idx, load_idx;
  logic                  req, ack, bus_we;
  logic                  unused_addr_bits;

  assign bus_idx  = address[ADDR_WIDTH+1:2];
  assign load_idx = load_addr[ADDR_WIDTH+1:2];
  assign req      = read ^ write;
  assign unused_addr_bits = ^{address[31:ADDR_WIDTH+2], load_addr[31:ADDR_WIDTH+2],
                              load_addr[1:0]};

  always_comb begin
    if (RANDOM_WAIT != 0) begin
      start_target = CntW'(32'(lfsr_q) % (WAIT_CYCLES + 1));
    end else begin
      start_target = CntW'(WAIT_CYCLES);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      target_q <= '0;
      lfsr_q   <= LFSR_SEED;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      lfsr_q   <= lfsr_d;
      err_q    <= err_d;
    end
  end

  // A loader cycle freezes the FSM so the stalled master simply sees one extra wait state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    lfsr_d   = lfsr_q;
    err_d    = err_q;
    if (read && write) err_d = 1'b1;
    if (!load_en) begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            target_d = start_target;
            if (address[1:0] != 2'b00) err_d = 1'b1;
            if (start_target > CntW'(1)) begin
              state_d = StWait;
              cnt_d   = CntW'(1);
            end else if (start_target == CntW'(1)) begin
              state_d = StAck;
            end
          end
        end
        StWait: begin
          if (!req) begin
            state_d = StIdle;
            cnt_d   = '0;
            err_d   = 1'b1;
          end else if (cnt_q + CntW'(1) == target_q) begin
            state_d = StAck;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StAck:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Zero-target transfers acknowledge in the same IDLE cycle that samples the request.
  always_comb begin
    ack         = 1'b0;
    waitrequest = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          ack         = (start_target == '0);
          waitrequest = (start_target != '0);
        end
      end
      StWait:  waitrequest = 1'b1;
      StAck:   ack = req;
      default: ;
    endcase
    if (load_en) begin
      waitrequest = 1'b1;
      ack         = 1'b0;
    end
    if (!reset) begin
      waitrequest = 1'b0;
      ack         = 1'b0;
    end
  end

  assign bus_we = ack && write;

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_idx] <= load_data;
    end else if (bus_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) mem[bus_idx][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

  assign readdata = read ? mem[bus_idx] : '0;
  assign err      = err_q;

endmodule

// File: doc/avalon_wait_ram.md
# avalon_wait_ram

Parametrised Avalon-MM slave memory model for the MIPS CPU test benches, connected directly to the CPU's `address/read/write/waitrequest/writedata/byteenable/readdata` master port. It succeeds the fixed zero-latency RAM with generalised depth and base window, byte-enable writes, a clocked program-loader port, and configurable fixed or pseudo-random wait-state insertion. It exercises the CPU's stall handling, which the zero-latency RAM never does.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: word-index bits; depth = 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, 2: maximum wait states per transfer (0 allowed).
- `RANDOM_WAIT`, 0: 0 = every transfer waits exactly `WAIT_CYCLES`; 1 = per-transfer wait drawn from an LFSR in 0..`WAIT_CYCLES`.
- `LFSR_SEED`, 16'hACE1: LFSR value after reset; must be nonzero.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `address` in 32: byte address from CPU.
- `read` in 1: read request.
- `write` in 1: write request.
- `waitrequest` out 1: slave stall.
- `writedata` in 32: write data.
- `byteenable` in 4: byte lanes; bit i enables `[8i+7:8i]`.
- `readdata` out 32: read data.
- `load_en` in 1: loader write strobe.
- `load_addr` in 32: loader byte address.
- `load_data` in 32: loader word.
- `err` out 1: sticky protocol-error flag.

## Operation
- Word index = `address[ADDR_WIDTH+1:2]`. Upper bits ignored, so the memory mirrors across the 4 GB space and `0xBFC00000` aliases index 0 when `ADDR_WIDTH` ≤ 20. The loader uses the same mapping on `load_addr`.
- Memory contents are not cleared by reset and persist across CPU resets.
- FSM states:
  - IDLE: no transfer in progress.
  - WAIT: counting wait states.
  - ACK: one cycle, `waitrequest` low.
- On reset: `state=IDLE`, `cnt=0`, `lfsr=LFSR_SEED`, `err=0`.
- Transfer start: in IDLE with `read^write` high, latch `target`.
  - `target = WAIT_CYCLES` when `RANDOM_WAIT=0`.
  - `target = lfsr % (WAIT_CYCLES+1)` when `RANDOM_WAIT=1`.
  - LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances once per transfer start only.
  - If `target==0`, that same cycle is the ACK cycle. Otherwise go to WAIT with `cnt=1`.
- WAIT: `cnt` increments each cycle. When `cnt==target`, the next cycle is ACK.
- `waitrequest` = 1 in IDLE with a request pending and `target>0`, or in WAIT. It is 0 in the ACK cycle and 0 in IDLE with no request.
  - Its reset value is 0.
  - It is forced to 1 in any cycle `load_en` is high; the FSM holds state during that cycle.
- Read: `readdata = mem[index]` combinationally whenever `read` is high. Otherwise `readdata = 0`. It is valid in the ACK cycle.
- Write: commits on the rising edge that ends the ACK cycle, only for lanes with `byteenable` set. `byteenable=0` is a legal no-op.
- After ACK, return to IDLE. A request still held by the master starts a new transfer.
- Master must hold `address/writedata/byteenable/read/write` stable while `waitrequest` is high.
- `err` is set (sticky until reset) on any of:
  - `read&&write` in the same cycle. The request is ignored and no transfer starts.
  - `address[1:0]!=0` at transfer start. The transfer proceeds with the low bits ignored.
  - A request dropped during WAIT. The FSM returns to IDLE with no write.
- Loader: on each rising edge with `load_en` high, `mem[load index] <= load_data` (full word).
  - It has priority over a bus write to the same word in the same edge; the bus write is not committed because `waitrequest` is forced high.
- Reset mid-transfer: FSM returns immediately to IDLE and `waitrequest` goes to 0. No partial write occurs; a write commits only on the ACK edge with `reset` high.

## Timing
- Bus latency: request sampled in cycle N, ACK in cycle N+target.
- Throughput: one transfer per target+1 cycles.
- `readdata` is combinational from `address`; there is no registered output stage.
- The loader needs one cycle per word. A loaded word is readable by the bus from the next cycle.

## Test plan
- WAIT_CYCLES=0: load `0x240ABFC0` at `0xBFC00004`, read `0xBFC00004` → `waitrequest` never high, `readdata=0x240ABFC0` in the same cycle.
- WAIT_CYCLES=3: write `0xDEADBEEF` to `0x10` with `byteenable=4'b0101`, over prior contents `0x11223344` → `waitrequest` high for 3 cycles then low for 1; readback `0x11AD33EF`.
- RANDOM_WAIT=1, WAIT_CYCLES=4: run 64 back-to-back reads → every stall length is in 0..4, at least two distinct lengths occur, and the sequence repeats identically after reset.
- `read&&write` asserted together, then a read at `0x2`:
  - `read&&write` → `err=1`, no transfer, memory unchanged.
  - read at `0x2` → returns the word at `0x0`, `err` stays 1.
- `load_en` pulsed during a WAIT-state read of the same word → `waitrequest` extended by 1 cycle; `readdata` at ACK equals the newly loaded value.
- `reset` driven low in cycle 2 of a 3-wait write → `waitrequest=0` immediately, target word unchanged, `err=0`, and after release the LFSR restarts from `0xACE1`.
